// File: rtl/spi_cmd_regfile.sv
// SPI command decoder and register file; one response byte per accepted rx byte, 1-cycle latency.
// No backpressure: every rx_valid seen while frame_active is high is consumed immediately.
module spi_cmd_regfile #(
  parameter int         NREGS   = 8,
  parameter int         ADDR_W  = $clog2(NREGS),
  parameter logic [7:0] ID_BYTE = 8'hA5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_active,
  input  logic                rx_valid,
  input  logic [7:0]          rx_byte,
  output logic                tx_valid,
  output logic [7:0]          tx_byte,
  output logic [NREGS*8-1:0]  reg_out,
  output logic                wr_strobe,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic                err_sticky
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    RDATA = 3'd3,
    ID    = 3'd4,
    STAT  = 3'd5,
    SKIP  = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_next_addr;
  logic                r_is_write;
  logic                w_next_is_write;
  logic [7:0]          r_regs [NREGS];
  logic [3:0]          r_wr_count;
  logic                r_tx_valid;
  logic [7:0]          r_tx_byte;
  logic                r_wr_strobe;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic                r_err;
  logic                w_accept;
  logic                w_wr_en;
  logic                w_err_set;
  logic                w_err_clr;
  logic [7:0]          w_tx_byte;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(NREGS - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  assign w_accept = frame_active & rx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Response byte is computed from the post-update address so READ data tracks auto-increment.
  always_comb begin
    w_next_state    = r_state;
    w_next_addr     = r_addr;
    w_next_is_write = r_is_write;
    w_wr_en         = 1'b0;
    w_err_set       = 1'b0;
    w_err_clr       = 1'b0;
    w_tx_byte       = 8'h00;
    if (!frame_active) begin
      w_next_state = IDLE;
    end else if (rx_valid) begin
      case (r_state)
        IDLE: begin
          case (rx_byte)
            8'h02: begin w_next_state = ADDR; w_next_is_write = 1'b1; end
            8'h03: begin w_next_state = ADDR; w_next_is_write = 1'b0; end
            8'h9F: w_next_state = ID;
            8'h05: w_next_state = STAT;
            default: begin w_next_state = SKIP; w_err_set = 1'b1; end
          endcase
        end
        ADDR: begin
          if (rx_byte < 8'(NREGS)) begin
            w_next_addr = rx_byte[ADDR_W-1:0];
            if (r_is_write) begin
              w_next_state = WDATA;
            end else begin
              w_next_state = RDATA;
              w_tx_byte    = r_regs[rx_byte[ADDR_W-1:0]];
            end
          end else begin
            w_next_state = SKIP;
            w_err_set    = 1'b1;
          end
        end
        WDATA: begin
          w_wr_en     = 1'b1;
          w_next_addr = addr_inc(r_addr);
        end
        RDATA: begin
          w_next_addr = addr_inc(r_addr);
          w_tx_byte   = r_regs[addr_inc(r_addr)];
        end
        ID:   w_tx_byte = ID_BYTE;
        STAT: begin
          w_tx_byte = {r_err, 3'b000, r_wr_count};
          w_err_clr = 1'b1;
        end
        default: w_tx_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_is_write  <= 1'b0;
      r_wr_count  <= 4'd0;
      r_tx_valid  <= 1'b0;
      r_tx_byte   <= 8'h00;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_err       <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= 8'h00;
    end else begin
      r_addr      <= w_next_addr;
      r_is_write  <= w_next_is_write;
      r_tx_valid  <= w_accept;
      r_wr_strobe <= w_wr_en;
      if (w_accept) r_tx_byte <= w_tx_byte;
      if (w_wr_en) begin
        r_regs[r_addr] <= rx_byte;
        r_wr_addr      <= r_addr;
        r_wr_count     <= r_wr_count + 4'd1;
      end
      // A new error in the same cycle as a status read keeps the flag set.
      if (w_err_set)      r_err <= 1'b1;
      else if (w_err_clr) r_err <= 1'b0;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NREGS; i++) reg_out[8*i +: 8] = r_regs[i];
  end

  assign tx_valid   = r_tx_valid;
  assign tx_byte    = r_tx_byte;
  assign wr_strobe  = r_wr_strobe;
  assign wr_addr    = r_wr_addr;
  assign err_sticky = r_err;

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Randomized + directed bench for spi_cmd_regfile with a frame-level reference model and tx scoreboard.
module tb_spi_cmd_regfile;

  localparam int NREGS  = 8;
  localparam int ADDR_W = 3;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int         due;
    logic [7:0] b;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                frame_active = 1'b0;
  logic                rx_valid = 1'b0;
  logic [7:0]          rx_byte = 8'h00;
  logic                tx_valid;
  logic [7:0]          tx_byte;
  logic [NREGS*8-1:0]  reg_out;
  logic                wr_strobe;
  logic [ADDR_W-1:0]   wr_addr;
  logic                err_sticky;

  spi_cmd_regfile #(.NREGS(NREGS), .ADDR_W(ADDR_W), .ID_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .frame_active(frame_active),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_valid(tx_valid), .tx_byte(tx_byte), .reg_out(reg_out),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   strobe_cnt = 0;
  exp_t sb[$];

  // Reference model state
  logic [7:0] m_regs [NREGS];
  logic       m_err = 1'b0;
  int         m_wcnt = 0;
  int         m_wr_addr = 0;
  int         m_writes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (wr_strobe) strobe_cnt++;
    if (tx_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_unexpected: got tx_byte %h with no pending byte (cycle %0d)", tx_byte, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("tx_byte", 64'(tx_byte), 64'(e.b));
        chk("tx_timing", 64'(cyc), 64'(e.due));
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL tx_missing: got no tx_valid expected byte %h due cycle %0d", sb[0].b, sb[0].due);
      void'(sb.pop_front());
    end
  end

  function automatic logic [NREGS*8-1:0] model_vec();
    logic [NREGS*8-1:0] v;
    v = '0;
    for (int i = 0; i < NREGS; i++) v[8*i +: 8] = m_regs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
    m_err     = 1'b0;
    m_wcnt    = 0;
    m_wr_addr = 0;
  endtask

  // Whole-frame protocol model: returns the expected response for every byte.
  task automatic model_frame(input bq_t b, output bq_t r);
    logic [7:0] cmd;
    logic [7:0] v;
    int         a;
    bit         dead;
    r    = {};
    a    = 0;
    dead = 0;
    if (b.size() == 0) return;
    cmd = b[0];
    r.push_back(8'h00);
    if (!(cmd inside {8'h02, 8'h03, 8'h9F, 8'h05})) begin
      m_err = 1'b1;
      dead  = 1;
    end
    for (int i = 1; i < b.size(); i++) begin
      v = 8'h00;
      if (!dead) begin
        if ((cmd == 8'h02 || cmd == 8'h03) && i == 1) begin
          if (int'(b[1]) >= NREGS) begin
            m_err = 1'b1;
            dead  = 1;
          end else begin
            a = int'(b[1]);
            if (cmd == 8'h03) v = m_regs[a];
          end
        end else if (cmd == 8'h02) begin
          m_regs[a] = b[i];
          m_wr_addr = a;
          m_wcnt    = (m_wcnt + 1) % 16;
          m_writes++;
          a = (a + 1) % NREGS;
        end else if (cmd == 8'h03) begin
          a = (a + 1) % NREGS;
          v = m_regs[a];
        end else if (cmd == 8'h9F) begin
          v = 8'hA5;
        end else begin
          v     = {m_err, 3'b000, 4'(m_wcnt)};
          m_err = 1'b0;
        end
      end
      r.push_back(v);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic drive_bytes(input bq_t b, input bq_t r);
    exp_t e;
    for (int i = 0; i < b.size(); i++) begin
      rx_valid = 1'b1;
      rx_byte  = b[i];
      e.due    = cyc + 1;
      e.b      = r[i];
      sb.push_back(e);
      @(negedge clk);
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending tx bytes expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_reg_out"}, 64'(reg_out), 64'(model_vec()));
    chk({tag, "_err"}, 64'(err_sticky), 64'(m_err));
    chk({tag, "_wr_addr"}, 64'(wr_addr), 64'(m_wr_addr));
    chk({tag, "_strobes"}, 64'(strobe_cnt), 64'(m_writes));
  endtask

  task automatic send_frame(input bq_t b, input string tag);
    bq_t r;
    model_frame(b, r);
    @(negedge clk);
    frame_active = 1'b1;
    @(negedge clk);
    drive_bytes(b, r);
    frame_active = 1'b0;
    drain();
    check_state(tag);
  endtask

  initial begin
    bq_t fb;
    bq_t r;
    int  len;
    int  sel;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_byte", 64'(tx_byte), 64'd0);
    chk("rst_reg_out", 64'(reg_out), 64'd0);
    chk("rst_wr_strobe", 64'(wr_strobe), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_err", 64'(err_sticky), 64'd0);
    rst_n = 1'b1;

    fb = {8'h02, 8'h03, 8'h5A, 8'hC3};
    send_frame(fb, "wr34");
    chk("wr34_reg3", 64'(reg_out[31:24]), 64'h5A);
    chk("wr34_reg4", 64'(reg_out[39:32]), 64'hC3);
    chk("wr34_wr_addr", 64'(wr_addr), 64'd4);
    fb = {8'h03, 8'h03, 8'h00, 8'h00};
    send_frame(fb, "rd345");
    fb = {8'h02, 8'h07, 8'h11, 8'h22};
    send_frame(fb, "wrwrap");
    chk("wrwrap_reg0", 64'(reg_out[7:0]), 64'h22);
    fb = {8'h03, 8'h07, 8'h00};
    send_frame(fb, "rdwrap");
    fb = {8'h77, 8'h12};
    send_frame(fb, "illegal");
    fb = {8'h05, 8'h00, 8'h00};
    send_frame(fb, "stat");
    fb = {8'h03, 8'h09};
    send_frame(fb, "badaddr");
    fb = {8'h9F, 8'h00, 8'h00};
    send_frame(fb, "id");
    fb = {8'h02, 8'h01};
    send_frame(fb, "dropwr");
    fb = {8'h03, 8'h01};
    send_frame(fb, "rd1");

    // rx_valid with the frame closed must be ignored entirely.
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = 8'h02;
    @(negedge clk);
    rx_valid = 1'b0;
    drain();
    check_state("noframe");

    for (int f = 0; f < 40; f++) begin
      fb  = {};
      sel = $urandom_range(0, 4);
      case (sel)
        0: fb.push_back(8'h02);
        1: fb.push_back(8'h03);
        2: fb.push_back(8'h9F);
        3: fb.push_back(8'h05);
        default: fb.push_back(8'($urandom));
      endcase
      len = $urandom_range(0, 5);
      if (len > 0) fb.push_back(8'($urandom_range(0, 9)));
      for (int k = 1; k < len; k++) fb.push_back(8'($urandom));
      send_frame(fb, "rand");
    end

    // Reset in the middle of a WRITE frame, then keep the frame open.
    fb = {8'h77};
    send_frame(fb, "preerr");
    fb = {8'h02, 8'h00, 8'hAA};
    model_frame(fb, r);
    @(negedge clk);
    frame_active = 1'b1;
    @(negedge clk);
    drive_bytes(fb, r);
    drain();
    chk("midrst_pre_reg0", 64'(reg_out[7:0]), 64'hAA);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_reg_out", 64'(reg_out), 64'd0);
    chk("midrst_err", 64'(err_sticky), 64'd0);
    chk("midrst_wr_addr", 64'(wr_addr), 64'd0);
    chk("midrst_tx_valid", 64'(tx_valid), 64'd0);
    chk("midrst_tx_byte", 64'(tx_byte), 64'd0);
    chk("midrst_wr_strobe", 64'(wr_strobe), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fb = {8'h00, 8'h11, 8'h22};
    model_frame(fb, r);
    drive_bytes(fb, r);
    frame_active = 1'b0;
    drain();
    check_state("postrst");
    chk("postrst_reg_out_zero", 64'(reg_out), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
